deserializer_1_to_10: RTL and testbench

// - 1:10 deserializer with word alignment for TMDS/DVI links. It is the receive-side counterpart of the 10:1 serializer.
// - Shifts in one bit per clk_i, LSB of each word first. Finds the word boundary from TMDS control tokens.
// - Outputs aligned 10-bit words with a valid strobe every 10 clocks. Sits between the line/IO sampler and the TMDS decoder.

---
 rtl/deserializer_1_to_10.sv | 161 ++++++++++++++++
 tb/tb_deserializer_1_to_10.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer_1_to_10.sv
// deserializer_1_to_10: 1:10 TMDS deserializer that finds the word boundary from control tokens.
// Define DESER_LOSS_CNT_EN to add loss_cnt_o, a saturating count of LOCKED->SEARCH transitions.
module deserializer_1_to_10 #(
   parameter int unsigned LOCK_MATCHES  = 4,
   parameter int unsigned TIMEOUT_WORDS = 2048
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ser_i,
   output logic [9:0] d_o,
   output logic       valid_o,
   output logic       ctrl_o,
   output logic       locked_o
`ifdef DESER_LOSS_CNT_EN
   ,
   output logic [7:0] loss_cnt_o
`endif
);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam logic [3:0]  LOCK_M       = 4'(LOCK_MATCHES);
   localparam logic [15:0] TIMEOUT_W    = 16'(TIMEOUT_WORDS);
   localparam logic [9:0]  CTRL_TOK [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

   state_t      state_q, state_d;
   logic [9:0]  sreg_q;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  match_cnt_q, match_cnt_d;
   logic [15:0] to_cnt_q, to_cnt_d;
   logic [9:0]  d_q, d_d;
   logic        valid_q, valid_d;
   logic        ctrl_q, ctrl_d;
   logic [3:0]  tok_hit;
   logic        tok;
   logic        boundary;
   logic [3:0]  match_inc;
   logic [15:0] to_inc;

   for (genvar gi = 0; gi < 4; gi++) begin : g_tok
      assign tok_hit[gi] = (sreg_q == CTRL_TOK[gi]);
   end

   assign tok       = |tok_hit;
   assign boundary  = (cnt_q == 4'd9);
   assign match_inc = match_cnt_q + 4'd1;
   assign to_inc    = to_cnt_q + 16'd1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_SEARCH;
         sreg_q      <= 10'd0;
         cnt_q       <= 4'd0;
         match_cnt_q <= 4'd0;
         to_cnt_q    <= 16'd0;
         d_q         <= 10'd0;
         valid_q     <= 1'b0;
         ctrl_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sreg_q      <= {ser_i, sreg_q[9:1]};
         cnt_q       <= cnt_d;
         match_cnt_q <= match_cnt_d;
         to_cnt_q    <= to_cnt_d;
         d_q         <= d_d;
         valid_q     <= valid_d;
         ctrl_q      <= ctrl_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = boundary ? 4'd0 : cnt_q + 4'd1;
      match_cnt_d = match_cnt_q;
      to_cnt_d    = to_cnt_q;
      d_d         = d_q;
      valid_d     = 1'b0;
      ctrl_d      = ctrl_q;
      case (state_q)
         ST_SEARCH: begin
            // Any bit position may start a token; restart the phase on the hit.
            if (tok) begin
               cnt_d       = 4'd0;
               match_cnt_d = 4'd1;
               state_d     = (LOCK_M == 4'd1) ? ST_LOCKED : ST_VERIFY;
            end
         end
         ST_VERIFY: begin
            if (boundary) begin
               if (tok) begin
                  match_cnt_d = match_inc;
                  if (match_inc >= LOCK_M) begin
                     state_d  = ST_LOCKED;
                     to_cnt_d = 16'd0;
                  end
               end else begin
                  match_cnt_d = 4'd0;
                  state_d     = ST_SEARCH;
               end
            end
         end
         ST_LOCKED: begin
            if (boundary) begin
               if (tok) begin
                  to_cnt_d = 16'd0;
                  d_d      = sreg_q;
                  valid_d  = 1'b1;
                  ctrl_d   = 1'b1;
               end else if (to_inc == TIMEOUT_W) begin
                  // The word that exhausts the timeout is dropped, not delivered.
                  state_d     = ST_SEARCH;
                  to_cnt_d    = 16'd0;
                  match_cnt_d = 4'd0;
               end else begin
                  to_cnt_d = to_inc;
                  d_d      = sreg_q;
                  valid_d  = 1'b1;
                  ctrl_d   = 1'b0;
               end
            end
         end
         default: begin
            state_d = ST_SEARCH;
         end
      endcase
   end

   assign d_o      = d_q;
   assign valid_o  = valid_q;
   assign ctrl_o   = ctrl_q;
   assign locked_o = (state_q == ST_LOCKED);

`ifdef DESER_LOSS_CNT_EN
   logic [7:0] loss_cnt_q, loss_cnt_d;
   logic       lock_lost;

   assign lock_lost = (state_q == ST_LOCKED) && (state_d == ST_SEARCH);

   always_comb begin
      loss_cnt_d = loss_cnt_q;
      if (lock_lost && (loss_cnt_q != 8'hFF)) begin
         loss_cnt_d = loss_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         loss_cnt_q <= 8'd0;
      end else begin
         loss_cnt_q <= loss_cnt_d;
      end
   end

   assign loss_cnt_o = loss_cnt_q;
`endif

endmodule

// File: tb/tb_deserializer_1_to_10.sv
// Self-checking bench for deserializer_1_to_10: scoreboard of expected words plus lock/timing checks.
// dut_a uses default parameters; dut_b uses TIMEOUT_WORDS=8 for the timeout and bit-slip scenarios.
module tb_deserializer_1_to_10;

   localparam logic [9:0] T_IDLE    = 10'h354;
   localparam logic [9:0] DATA8 [8] = '{10'h155, 10'h2AA, 10'h0F0, 10'h30F,
                                        10'h001, 10'h3FE, 10'h123, 10'h2DC};

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       ser_i = 1'b0;

   logic [9:0] d_a, d_b;
   logic       valid_a, valid_b, ctrl_a, ctrl_b, locked_a, locked_b;
`ifdef DESER_LOSS_CNT_EN
   logic [7:0] loss_a, loss_b;
`endif

   bit         sel_b = 1'b0;
   logic [9:0] obs_d;
   logic       obs_valid, obs_ctrl, obs_locked;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc            = 0;
   int          last_valid_cyc = -1;
   int          lock_cyc       = -1;
   int          pulse_cnt      = 0;
   logic [10:0] exp_q[$];

   always #5 clk = ~clk;

   deserializer_1_to_10 dut_a (
      .clk_i      (clk),
      .rst_i      (rst),
      .ser_i      (ser_i),
      .d_o        (d_a),
      .valid_o    (valid_a),
      .ctrl_o     (ctrl_a),
      .locked_o   (locked_a)
`ifdef DESER_LOSS_CNT_EN
      ,
      .loss_cnt_o (loss_a)
`endif
   );

   deserializer_1_to_10 #(.LOCK_MATCHES(4), .TIMEOUT_WORDS(8)) dut_b (
      .clk_i      (clk),
      .rst_i      (rst),
      .ser_i      (ser_i),
      .d_o        (d_b),
      .valid_o    (valid_b),
      .ctrl_o     (ctrl_b),
      .locked_o   (locked_b)
`ifdef DESER_LOSS_CNT_EN
      ,
      .loss_cnt_o (loss_b)
`endif
   );

   assign obs_d      = sel_b ? d_b      : d_a;
   assign obs_valid  = sel_b ? valid_b  : valid_a;
   assign obs_ctrl   = sel_b ? ctrl_b   : ctrl_a;
   assign obs_locked = sel_b ? locked_b : locked_a;

   function automatic logic is_tok(input logic [9:0] w);
      return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
   endfunction

   task automatic clear_books();
      cyc            = 0;
      last_valid_cyc = -1;
      lock_cyc       = -1;
      pulse_cnt      = 0;
      exp_q.delete();
   endtask

   task automatic do_reset();
      ser_i = 1'b0;
      rst   = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      clear_books();
   endtask

   // One serial bit; outputs are sampled 1 time unit after the edge.
   task automatic send_bit(input logic b);
      logic [10:0] want;
      ser_i = b;
      @(posedge clk);
      #1;
      cyc++;
      if (obs_locked === 1'b1 && lock_cyc < 0) lock_cyc = cyc;
      if (obs_valid === 1'b1) begin
         pulse_cnt++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_valid: got d_o=%h ctrl_o=%b at cycle %0d, required no strobe",
                     obs_d, obs_ctrl, cyc);
         end else begin
            want = exp_q.pop_front();
            if ({obs_ctrl, obs_d} !== want) begin
               n_fail++;
               $display("FAIL word: got ctrl_o=%b d_o=%h, required ctrl_o=%b d_o=%h (cycle %0d)",
                        obs_ctrl, obs_d, want[10], want[9:0], cyc);
            end
         end
         if (last_valid_cyc >= 0) begin
            n_checks++;
            if (cyc - last_valid_cyc != 10) begin
               n_fail++;
               $display("FAIL valid_period: got %0d cycles between strobes, required 10",
                        cyc - last_valid_cyc);
            end
         end
         last_valid_cyc = cyc;
      end
   endtask

   task automatic send_word(input logic [9:0] w, input bit expect_out);
      if (expect_out) exp_q.push_back({is_tok(w), w});
      for (int i = 0; i < 10; i++) send_bit(w[i]);
   endtask

   task automatic check_drained(input string name);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: got %0d words never delivered, required 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({d_a, valid_a, ctrl_a, locked_a} !== 13'h0) begin
         n_fail++;
         $display("FAIL reset_a: got d=%h v=%b c=%b l=%b, required all 0", d_a, valid_a, ctrl_a, locked_a);
      end
      n_checks++;
      if ({d_b, valid_b, ctrl_b, locked_b} !== 13'h0) begin
         n_fail++;
         $display("FAIL reset_b: got d=%h v=%b c=%b l=%b, required all 0", d_b, valid_b, ctrl_b, locked_b);
      end
`ifdef DESER_LOSS_CNT_EN
      n_checks++;
      if (loss_a !== 8'd0 || loss_b !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_loss: got %0d/%0d, required 0/0", loss_a, loss_b);
      end
`endif
      $display("test_reset done");
   endtask

   // Stream starts mid-word: 'o' trailing bits of a token, then whole tokens.
   // Offsets 8 and 9 leave the reset zeros standing in for the token's two low
   // zero bits, so the first aligned hit comes one word earlier.
   task automatic test_idle_link();
      logic [9:0] tv;
      int         first_out;
      tv    = T_IDLE;
      sel_b = 1'b0;
      for (int o = 0; o < 10; o++) begin
         do_reset();
         for (int i = 10 - o; i < 10; i++) send_bit(tv[i]);
         first_out = (o >= 8) ? 3 : 4;
         for (int k = 0; k < 10; k++) send_word(tv, k >= first_out);
         send_bit(1'b0);
         n_checks++;
         if (lock_cyc < 0 || lock_cyc > 50 + o) begin
            n_fail++;
            $display("FAIL idle_lock_time: offset %0d got lock at cycle %0d, required 1..%0d",
                     o, lock_cyc, 50 + o);
         end
         check_drained("idle");
         $display("test_idle_link offset %0d lock at cycle %0d", o, lock_cyc);
      end
   endtask

   task automatic test_data_after_lock();
      logic [9:0] tv, w;
      tv    = T_IDLE;
      sel_b = 1'b0;
      do_reset();
      for (int k = 0; k < 16; k++) send_word(tv, k >= 4);
      for (int k = 0; k < 100; k++) begin
         if (k < 10) w = (k % 2 == 0) ? 10'h155 : 10'h2AA;
         else begin
            w = 10'($urandom_range(0, 1023));
            if (is_tok(w)) w = w ^ 10'h001;
         end
         send_word(w, 1'b1);
         n_checks++;
         if (locked_a !== 1'b1) begin
            n_fail++;
            $display("FAIL data_locked: word %0d got locked_o=%b, required 1", k, locked_a);
         end
      end
      send_bit(1'b0);
      check_drained("data");
      $display("test_data_after_lock done, %0d strobes", pulse_cnt);
   endtask

   task automatic test_false_start();
      logic [9:0] tv;
      tv    = T_IDLE;
      sel_b = 1'b0;
      do_reset();
      send_word(tv, 1'b0);
      send_word(10'h000, 1'b0);
      n_checks++;
      if (locked_a !== 1'b0) begin
         n_fail++;
         $display("FAIL false_start_locked: got locked_o=%b, required 0", locked_a);
      end
      // Back in SEARCH: the next four tokens must be needed again before lock.
      for (int k = 0; k < 4; k++) send_word(tv, 1'b0);
      n_checks++;
      if (locked_a !== 1'b0) begin
         n_fail++;
         $display("FAIL false_start_early_lock: got locked_o=%b, required 0", locked_a);
      end
      send_word(tv, 1'b1);
      send_bit(1'b0);
      n_checks++;
      if (locked_a !== 1'b1 || pulse_cnt != 1) begin
         n_fail++;
         $display("FAIL false_start_relock: got locked_o=%b strobes=%0d, required 1 and 1",
                  locked_a, pulse_cnt);
      end
      check_drained("false_start");
      $display("test_false_start done");
   endtask

   task automatic test_timeout();
      logic [9:0] tv, w;
      tv    = T_IDLE;
      sel_b = 1'b1;
      do_reset();
      for (int k = 0; k < 6; k++) send_word(tv, k >= 4);
`ifdef DESER_LOSS_CNT_EN
      n_checks++;
      if (loss_b !== 8'd0) begin
         n_fail++;
         $display("FAIL timeout_loss_before: got %0d, required 0", loss_b);
      end
`endif
      for (int k = 0; k < 8; k++) begin
         w = DATA8[k];
         send_word(w, k < 7);
      end
      n_checks++;
      if (locked_b !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_early_drop: got locked_o=%b at 8th boundary, required 1", locked_b);
      end
      send_bit(1'b0);
      n_checks++;
      if (locked_b !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_drop: got locked_o=%b, required 0", locked_b);
      end
      // Two token strobes before the data, then 7 data strobes.
      n_checks++;
      if (pulse_cnt != 9) begin
         n_fail++;
         $display("FAIL timeout_pulses: got %0d strobes, required 9 (2 token + 7 data)", pulse_cnt);
      end
`ifdef DESER_LOSS_CNT_EN
      n_checks++;
      if (loss_b !== 8'd1) begin
         n_fail++;
         $display("FAIL timeout_loss_after: got %0d, required 1", loss_b);
      end
`endif
      check_drained("timeout");
      $display("test_timeout done");
   endtask

   task automatic test_bit_slip();
      logic [9:0] tv, slip_w;
      tv     = T_IDLE;
      // Old-phase window after one inserted bit: newest 9 bits of a token over a 1.
      slip_w = {tv[8:0], 1'b1};
      sel_b  = 1'b1;
      do_reset();
      for (int k = 0; k < 6; k++) send_word(tv, k >= 4);
      send_bit(1'b1);
      for (int k = 0; k < 14; k++) begin
         if (k <= 6) exp_q.push_back({1'b0, slip_w});
         send_word(tv, k >= 11);
         if (k == 7) begin
            last_valid_cyc = -1;
            n_checks++;
            if (locked_b !== 1'b0) begin
               n_fail++;
               $display("FAIL slip_timeout: got locked_o=%b, required 0", locked_b);
            end
         end
         if (k == 10) begin
            n_checks++;
            if (locked_b !== 1'b0) begin
               n_fail++;
               $display("FAIL slip_early_relock: got locked_o=%b, required 0", locked_b);
            end
         end
         if (k == 11) begin
            n_checks++;
            if (locked_b !== 1'b1) begin
               n_fail++;
               $display("FAIL slip_relock: got locked_o=%b, required 1", locked_b);
            end
         end
      end
      send_bit(1'b0);
      check_drained("slip");
`ifdef DESER_LOSS_CNT_EN
      n_checks++;
      if (loss_b !== 8'd1) begin
         n_fail++;
         $display("FAIL slip_loss: got %0d, required 1", loss_b);
      end
`endif
      $display("test_bit_slip done");
   endtask

   task automatic test_reset_mid_lock();
      logic [9:0] tv;
      tv    = T_IDLE;
      sel_b = 1'b0;
      do_reset();
      for (int k = 0; k < 6; k++) send_word(tv, k >= 4);
      for (int i = 0; i < 6; i++) send_bit(tv[i]);
      n_checks++;
      if (locked_a !== 1'b1 || d_a !== T_IDLE || ctrl_a !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset: got l=%b d=%h c=%b, required 1 354 1", locked_a, d_a, ctrl_a);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({d_a, valid_a, ctrl_a, locked_a} !== 13'h0) begin
         n_fail++;
         $display("FAIL async_reset: got d=%h v=%b c=%b l=%b, required all 0",
                  d_a, valid_a, ctrl_a, locked_a);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      clear_books();
      for (int k = 0; k < 10; k++) send_word(tv, k >= 4);
      send_bit(1'b0);
      n_checks++;
      if (lock_cyc < 0 || lock_cyc > 50) begin
         n_fail++;
         $display("FAIL reset_relock_time: got lock at cycle %0d, required 1..50", lock_cyc);
      end
      check_drained("reset_relock");
      $display("test_reset_mid_lock done, relock at cycle %0d", lock_cyc);
   endtask

   initial begin
      test_reset();
      test_idle_link();
      test_data_after_lock();
      test_false_start();
      test_timeout();
      test_bit_slip();
      test_reset_mid_lock();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
